// File: rtl/counter_scheduler.sv
// Two-requester round-robin scheduler that lends one shared up-counter to the
// winner, counts to that requester's latched length, then pulses done.
module counter_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] len0_i,
    input  logic [WIDTH-1:0] len1_i,
    output logic [1:0]       grant_o,
    output logic [1:0]       done_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] counter_value_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       grant_q;
    logic [1:0]       done_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] len_q;
    logic             prio_q;     // index of the requester that wins a tie
    logic             win_d;
    logic             owner;
    logic             owner_req;

    // A lone request wins outright; only a tie consults the pointer.
    always_comb begin
        win_d = prio_q;
        if (req_i == 2'b01) begin
            win_d = 1'b0;
        end else if (req_i == 2'b10) begin
            win_d = 1'b1;
        end
    end

    assign owner     = grant_q[1];
    assign owner_req = req_i[owner];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            count_q <= '0;
            len_q   <= '0;
            prio_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 2'b00;
                    if (|req_i) begin
                        state_q <= RUN;
                        grant_q <= win_d ? 2'b10 : 2'b01;
                        count_q <= '0;
                        len_q   <= win_d ? len1_i : len0_i;
                    end
                end
                RUN: begin
                    // A withdrawn request beats terminal count in the same cycle.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        prio_q  <= ~owner;
                    end else if (enable_i) begin
                        if (count_q == len_q) begin
                            state_q <= DONE;
                            done_q  <= grant_q;
                            grant_q <= 2'b00;
                            prio_q  <= ~owner;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 2'b00;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                    done_q  <= 2'b00;
                end
            endcase
        end
    end

    assign grant_o         = grant_q;
    assign done_o          = done_q;
    assign busy_o          = (state_q != IDLE);
    assign counter_value_o = count_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: a per-cycle vector table plus
// hand-written sequences for the reset glitch and the full-length job.
module tb_counter_scheduler;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       enable_i = 1'b1;
    logic [1:0] req_i = 2'b00;
    logic [3:0] len0_i = 4'd0;
    logic [3:0] len1_i = 4'd0;
    logic [1:0] grant_o;
    logic [1:0] done_o;
    logic       busy_o;
    logic [3:0] counter_value_o;

    int total = 0;
    int bad = 0;
    bit monitor_on = 1'b0;

    counter_scheduler #(.WIDTH(4)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .enable_i        (enable_i),
        .req_i           (req_i),
        .len0_i          (len0_i),
        .len1_i          (len1_i),
        .grant_o         (grant_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .counter_value_o (counter_value_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] req;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [1:0] g;
        logic [1:0] d;
        logic       b;
        logic [3:0] c;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic [1:0] req,
                       input logic [3:0] l0, input logic [3:0] l1,
                       input logic [1:0] g, input logic [1:0] d,
                       input logic b, input logic [3:0] c);
        vec_t v;
        v.rst = rst; v.en = en; v.req = req; v.l0 = l0; v.l1 = l1;
        v.g = g; v.d = d; v.b = b; v.c = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s %s: got %0h want %0h", tag, nm, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, check 1ns later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clock_i);
        reset_i = v.rst; enable_i = v.en; req_i = v.req; len0_i = v.l0; len1_i = v.l1;
        @(posedge clock_i);
        #1;
        chk("grant", tag, int'(grant_o), int'(v.g));
        chk("done", tag, int'(done_o), int'(v.d));
        chk("busy", tag, int'(busy_o), int'(v.b));
        chk("count", tag, int'(counter_value_o), int'(v.c));
        $display("%s: rst=%0b en=%0b req=%b l0=%0d l1=%0d -> grant=%b done=%b busy=%0b cnt=%0d",
                 tag, v.rst, v.en, v.req, v.l0, v.l1, grant_o, done_o, busy_o, counter_value_o);
    endtask

    always @(negedge clock_i) begin
        if (monitor_on) begin
            total++;
            if (!$onehot0(grant_o) || !$onehot0(done_o)) begin
                bad++;
                $display("FAIL onehot: got grant=%b done=%b want zero-or-one-hot", grant_o, done_o);
            end
        end
    end

    initial begin
        vec_t v;
        string tag;

        //   rst en req    l0 l1  grant  done  b  cnt
        add(1, 1, 2'b00, 2, 0, 2'b00, 2'b00, 0, 0);   // reset
        add(0, 1, 2'b01, 2, 0, 2'b01, 2'b00, 1, 0);   // single job len 2
        add(0, 1, 2'b01, 2, 0, 2'b01, 2'b00, 1, 1);
        add(0, 1, 2'b01, 2, 0, 2'b01, 2'b00, 1, 2);
        add(0, 1, 2'b01, 2, 0, 2'b00, 2'b01, 1, 2);
        add(0, 1, 2'b00, 2, 0, 2'b00, 2'b00, 0, 2);
        add(1, 1, 2'b11, 1, 1, 2'b00, 2'b00, 0, 0);   // round robin from reset
        add(0, 1, 2'b11, 1, 1, 2'b01, 2'b00, 1, 0);
        add(0, 1, 2'b11, 1, 1, 2'b01, 2'b00, 1, 1);
        add(0, 1, 2'b11, 1, 1, 2'b00, 2'b01, 1, 1);
        add(0, 1, 2'b11, 1, 1, 2'b00, 2'b00, 0, 1);
        add(0, 1, 2'b11, 1, 1, 2'b10, 2'b00, 1, 0);
        add(0, 1, 2'b11, 1, 1, 2'b10, 2'b00, 1, 1);
        add(0, 1, 2'b11, 1, 1, 2'b00, 2'b10, 1, 1);
        add(0, 1, 2'b11, 1, 1, 2'b00, 2'b00, 0, 1);
        add(0, 1, 2'b11, 1, 1, 2'b01, 2'b00, 1, 0);
        add(1, 1, 2'b00, 5, 0, 2'b00, 2'b00, 0, 0);   // abandon, pending req1
        add(0, 1, 2'b01, 5, 0, 2'b01, 2'b00, 1, 0);
        add(0, 1, 2'b11, 5, 0, 2'b01, 2'b00, 1, 1);
        add(0, 1, 2'b11, 5, 0, 2'b01, 2'b00, 1, 2);
        add(0, 1, 2'b10, 5, 0, 2'b00, 2'b00, 0, 2);
        add(0, 1, 2'b10, 5, 0, 2'b10, 2'b00, 1, 0);
        add(0, 1, 2'b10, 5, 0, 2'b00, 2'b10, 1, 0);   // length 0
        add(0, 1, 2'b00, 5, 0, 2'b00, 2'b00, 0, 0);
        add(0, 1, 2'b10, 0, 3, 2'b10, 2'b00, 1, 0);   // enable pause, len change ignored
        add(0, 1, 2'b10, 0, 3, 2'b10, 2'b00, 1, 1);
        add(0, 0, 2'b10, 0, 0, 2'b10, 2'b00, 1, 1);
        add(0, 0, 2'b10, 0, 0, 2'b10, 2'b00, 1, 1);
        add(0, 1, 2'b10, 0, 0, 2'b10, 2'b00, 1, 2);
        add(0, 1, 2'b10, 0, 0, 2'b10, 2'b00, 1, 3);
        add(0, 1, 2'b10, 0, 0, 2'b00, 2'b10, 1, 3);
        add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 3);
        add(0, 1, 2'b01, 7, 0, 2'b01, 2'b00, 1, 0);   // reset mid-run
        add(0, 1, 2'b01, 7, 0, 2'b01, 2'b00, 1, 1);
        add(0, 1, 2'b01, 7, 0, 2'b01, 2'b00, 1, 2);
        add(0, 1, 2'b01, 7, 0, 2'b01, 2'b00, 1, 3);
        add(1, 1, 2'b01, 7, 0, 2'b00, 2'b00, 0, 0);
        add(0, 1, 2'b00, 7, 0, 2'b00, 2'b00, 0, 0);
        add(0, 1, 2'b01, 0, 0, 2'b01, 2'b00, 1, 0);   // abandon beats terminal
        add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        add(0, 1, 2'b11, 0, 0, 2'b10, 2'b00, 1, 0);   // pointer moved by abandon
        add(0, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 0);
        add(0, 1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0);
        add(0, 1, 2'b11, 0, 0, 2'b01, 2'b00, 1, 0);
        add(0, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);

        monitor_on = 1'b1;
        foreach (vecs[i]) begin
            tag = $sformatf("row%0d", i);
            apply(vecs[i], tag);
        end

        // Reset raised and dropped between edges must be invisible.
        v = '{rst: 0, en: 1, req: 2'b01, l0: 3, l1: 0, g: 2'b01, d: 2'b00, b: 1, c: 0};
        apply(v, "glitch_grant");
        v.c = 1;
        apply(v, "glitch_c1");
        @(negedge clock_i);
        reset_i = 1'b1;
        #2;
        reset_i = 1'b0;
        @(posedge clock_i);
        #1;
        chk("grant", "glitch_after", int'(grant_o), 2'b01);
        chk("busy", "glitch_after", int'(busy_o), 1);
        chk("count", "glitch_after", int'(counter_value_o), 2);
        $display("glitch_after: grant=%b busy=%0b cnt=%0d", grant_o, busy_o, counter_value_o);
        v = '{rst: 0, en: 1, req: 2'b00, l0: 3, l1: 0, g: 2'b00, d: 2'b00, b: 0, c: 2};
        apply(v, "glitch_abandon");

        // Maximum length: 16 RUN cycles counting 0..15, then done, no wrap.
        v = '{rst: 0, en: 1, req: 2'b01, l0: 15, l1: 0, g: 2'b01, d: 2'b00, b: 1, c: 0};
        for (int k = 0; k < 16; k++) begin
            v.c = 4'(k);
            apply(v, $sformatf("max_c%0d", k));
        end
        v.g = 2'b00; v.d = 2'b01; v.c = 15;
        apply(v, "max_done");
        v.req = 2'b00; v.d = 2'b00; v.b = 0;
        apply(v, "max_idle");

        monitor_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
